// File: rtl/ram_tp_pkg.sv
// ram_tp_pkg: shared constants, clear-sequencer state encoding and the
// clog2 helper for the lane-masked true-pipelined RAM (ram_tp_param).
package ram_tp_pkg;

  localparam int DEF_DWIDTH       = 32;
  localparam int DEF_DEPTH        = 1024;
  localparam int DEF_LANE_W       = 8;
  localparam int DEF_PIPE         = 1;
  localparam int DEF_CLR_ON_RESET = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Smallest r with 2**r >= v (v >= 2 is assumed by the callers).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram_tp_array.sv
// ram_tp_array: plain storage. One write port with per-lane enables and one
// registered read port. Kept free of bypass/reset logic so it can be swapped
// for a vendor RAM primitive.
//   clk   : clock
//   we    : write enable (address must already be in range)
//   wbe   : per-lane write enable, lane i covers wd[i*LANE_W +: LANE_W]
//   waddr : write address
//   wd    : write data
//   re    : read enable
//   raddr : read address
//   rd    : registered read data (old contents on same-address collision)
module ram_tp_array #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 1024,
  parameter int LANE_W = 8,
  parameter int NLANES = DWIDTH / LANE_W,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NLANES-1:0] wbe,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wd,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rd
);

  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_W)) begin
      for (int i = 0; i < NLANES; i++)
        if (wbe[i]) mem[waddr][i*LANE_W +: LANE_W] <= wd[i*LANE_W +: LANE_W];
    end
    // Out-of-range reads leave rd alone; the caller masks them to zero.
    if (re && ({1'b0, raddr} < DEPTH_W)) rd <= mem[raddr];
  end

endmodule

// File: rtl/ram_tp_param.sv
// ram_tp_param: single-clock RAM with lane write enables, write-first
// same-edge collision bypass, optional output register and a post-reset
// zero-fill sweep.
//   RWCLK  : clock          RESET : sync active-high reset
//   WEN/WBE/WADDR/WD        : write request, lane enables, address, data
//   REN/RADDR               : read request and address
//   RD/RVALID               : read data (held between results), 1-cycle strobe
//   BUSY                    : clear sweep running, requests ignored
module ram_tp_param
  import ram_tp_pkg::*;
#(
  parameter int DWIDTH       = DEF_DWIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int LANE_W       = DEF_LANE_W,
  parameter int PIPE         = DEF_PIPE,
  parameter int CLR_ON_RESET = DEF_CLR_ON_RESET,
  localparam int NLANES      = DWIDTH / LANE_W,
  localparam int AWIDTH      = clog2(DEPTH)
) (
  input  logic              RWCLK,
  input  logic              RESET,
  input  logic              WEN,
  input  logic [NLANES-1:0] WBE,
  input  logic [AWIDTH-1:0] WADDR,
  input  logic [DWIDTH-1:0] WD,
  input  logic              REN,
  input  logic [AWIDTH-1:0] RADDR,
  output logic [DWIDTH-1:0] RD,
  output logic              RVALID,
  output logic              BUSY
);

  if (DWIDTH % LANE_W != 0) begin : g_err_lane
    $error("ram_tp_param: DWIDTH must be a multiple of LANE_W");
  end
  if (PIPE < 0 || PIPE > 1) begin : g_err_pipe
    $error("ram_tp_param: PIPE must be 0 or 1");
  end
  if (DEPTH < 2) begin : g_err_depth
    $error("ram_tp_param: DEPTH must be at least 2");
  end

  // vld_pipe[0]: array output valid; vld_pipe[STAGES]: RVALID.
  localparam int STAGES = 1 + PIPE;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

  clr_state_e        state;
  logic [AWIDTH-1:0] clr_cnt;
  logic              busy;
  logic              wr_ok, rd_ok;
  logic              a_we;
  logic [NLANES-1:0] a_wbe;
  logic [AWIDTH-1:0] a_waddr;
  logic [DWIDTH-1:0] a_wd, a_rd;
  logic [NLANES-1:0] byp_mask;
  logic [DWIDTH-1:0] byp_data;
  logic              rd_oob;
  logic [DWIDTH-1:0] merged, rd_q;
  logic [STAGES:0]   vld_pipe;

  assign busy  = (CLR_ON_RESET != 0) && (state == CLEAR);
  assign wr_ok = WEN && !busy && ({1'b0, WADDR} < DEPTH_W);
  assign rd_ok = REN && !busy;

  // Clear sequencer: one zero word per cycle, restarts from 0 on every reset.
  always_ff @(posedge RWCLK) begin
    if (RESET) begin
      state   <= (CLR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + AWIDTH'(1);
      if (clr_cnt == AWIDTH'(DEPTH - 1)) state <= IDLE;
    end
  end

  // The sweep owns the write port; reset itself never writes the array.
  assign a_we    = (busy && !RESET) || wr_ok;
  assign a_wbe   = busy ? '1 : WBE;
  assign a_waddr = busy ? clr_cnt : WADDR;
  assign a_wd    = busy ? '0 : WD;

  ram_tp_array #(
    .DWIDTH(DWIDTH), .DEPTH(DEPTH), .LANE_W(LANE_W),
    .NLANES(NLANES), .AWIDTH(AWIDTH)
  ) u_array (
    .clk(RWCLK), .we(a_we), .wbe(a_wbe), .waddr(a_waddr), .wd(a_wd),
    .re(rd_ok), .raddr(RADDR), .rd(a_rd)
  );

  // The array returns pre-write data on a same-edge collision, so remember
  // which lanes were written alongside the read and patch them afterwards.
  always_ff @(posedge RWCLK) begin
    byp_mask <= (wr_ok && (WADDR == RADDR)) ? WBE : '0;
    byp_data <= WD;
    rd_oob   <= ({1'b0, RADDR} >= DEPTH_W);
  end

  always_comb begin
    merged = a_rd;
    for (int i = 0; i < NLANES; i++)
      if (byp_mask[i]) merged[i*LANE_W +: LANE_W] = byp_data[i*LANE_W +: LANE_W];
    if (rd_oob) merged = '0;
  end

  always_ff @(posedge RWCLK) begin
    if (RESET) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:0], rd_ok};
  end

  // RD only moves when a result lands, so it holds between strobes.
  if (PIPE == 1) begin : g_pipe
    logic [DWIDTH-1:0] s1_q;
    always_ff @(posedge RWCLK) begin
      if (vld_pipe[0]) s1_q <= merged;
      if (RESET)            rd_q <= '0;
      else if (vld_pipe[1]) rd_q <= s1_q;
    end
  end else begin : g_nopipe
    always_ff @(posedge RWCLK) begin
      if (RESET)            rd_q <= '0;
      else if (vld_pipe[0]) rd_q <= merged;
    end
  end

  assign RD     = rd_q;
  assign RVALID = vld_pipe[STAGES];
  assign BUSY   = busy;

endmodule

// File: doc/ram_tp_param.md
RAM_TP_PARAM -- requirements
Module: ram_tp_param

Interface
REQ-001 Parameter DWIDTH, default 32: data word width in bits; SHALL be a multiple of LANE_W.
REQ-002 Parameter DEPTH, default 1024: number of words; SHALL be at least 2.
REQ-003 Parameter LANE_W, default 8: width of one write-enable lane; NLANES = DWIDTH/LANE_W.
REQ-004 Parameter PIPE, default 1, legal values 0 or 1: extra output register stage.
REQ-005 Parameter CLR_ON_RESET, default 1: 1 zero-fills the whole array after reset.
REQ-006 AWIDTH SHALL equal ceil(log2(DEPTH)) and SHALL be derived, not set by the user.
REQ-007 RWCLK  in  1  single clock; all ports sampled and driven on the rising edge.
REQ-008 RESET  in  1  reset; one clock, synchronous and active-high.
REQ-009 WEN  in  1  write request.
REQ-010 WBE  in  NLANES  per-lane write enable; bit i covers WD[i*LANE_W +: LANE_W].
REQ-011 WADDR  in  AWIDTH  write address.
REQ-012 WD  in  DWIDTH  write data.
REQ-013 REN  in  1  read request.
REQ-014 RADDR  in  AWIDTH  read address.
REQ-015 RD  out  DWIDTH  read data.
REQ-016 RVALID  out  1  RD carries the result of an accepted read, one-cycle strobe.
REQ-017 BUSY  out  1  clear sweep in progress; requests are ignored.

Function
REQ-018 A write SHALL be accepted at an edge where WEN=1 and BUSY=0; only lanes with WBE=1 are updated.
REQ-019 An accepted write with WADDR >= DEPTH SHALL be dropped with no side effect.
REQ-020 A read SHALL be accepted at an edge where REN=1 and BUSY=0.
REQ-021 An accepted read at edge N SHALL present RD with RVALID=1 in the cycle after edge N+1+PIPE.
- Read latency is 1+PIPE cycles.
- Fully pipelined: one read per cycle.
REQ-022 RD SHALL hold its last value while RVALID=0.
REQ-023 A read with RADDR >= DEPTH SHALL return all zeros with RVALID=1.
REQ-024 Read and write to the same address at the same edge SHALL be write-first, per lane:
- lanes with WBE=1 return the new WD;
- other lanes return the prior contents.
REQ-025 A read accepted at the edge immediately after a write to the same address SHALL return the updated word.
REQ-026 Clear sweep, CLR_ON_RESET=1, states IDLE and CLEAR:
- RESET enters CLEAR with counter=0.
- CLEAR writes zero to address counter every cycle after RESET deasserts, then increments counter.
- After the write to DEPTH-1, the sweep moves to IDLE; BUSY falls at that edge.
- The sweep SHALL take exactly DEPTH cycles after RESET deasserts.
REQ-027 BUSY SHALL be 1 in every cycle of CLEAR and while RESET is high; with CLR_ON_RESET=0, BUSY SHALL be constant 0.
REQ-028 WEN and REN asserted while BUSY=1 SHALL be ignored: no write, no RVALID.

Reset
REQ-029 At the edge where RESET=1, outputs SHALL become: RD=0, RVALID=0, BUSY=CLR_ON_RESET.
REQ-030 RESET SHALL flush all in-flight reads; no RVALID is issued for reads accepted before reset.
REQ-031 RESET mid-sweep SHALL restart the sweep from address 0.
REQ-032 Array contents SHALL change only through accepted writes and the clear sweep, never directly by RESET.

Structure
REQ-033 Package ram_tp_pkg SHALL hold:
- the clog2 function;
- default parameter constants;
- the IDLE/CLEAR state encoding.
REQ-034 Storage SHALL be in sub-module ram_tp_array: one write port with lane enables and one registered read port, replaceable by a vendor primitive.
REQ-035 Collision bypass, PIPE stage, RVALID pipeline and clear sequencer SHALL live in ram_tp_param.
REQ-036 Illegal parameters SHALL stop elaboration with an error: DWIDTH%LANE_W!=0, PIPE>1, DEPTH<2.

Verification
REQ-037 Defaults, reset 3 cycles, then release -> BUSY=1 for exactly 1024 cycles; a read of address 517 afterwards returns 0x00000000.
REQ-038 Write 0xDEADBEEF at address 5, then WBE=4'b0101 with WD=0x11223344 at address 5; read 5 -> RD=0xDE22BE44, RVALID exactly 2 cycles after acceptance.
REQ-039 Same-edge write 0xA5A5A5A5 (WBE=4'b1111) and read at address 9, array word 0 -> RD=0xA5A5A5A5.
REQ-040 Back-to-back reads of addresses 0..7 on consecutive edges, after writing word=address -> RVALID high for 8 consecutive cycles, RD=0..7 in order.
REQ-041 PIPE=0, DEPTH=1000: read 999 returns the stored word after 1 cycle; read 1000 returns 0 with RVALID=1; write to 1000 changes nothing.
REQ-042 RESET asserted with 2 reads in flight and the sweep at address 300 -> no RVALID for those reads; the sweep restarts at 0 and BUSY lasts DEPTH cycles.
